// File: rtl/seq_disp_pkg.sv
// Shared constants for the sequence-event display: segment bit positions,
// the hex-to-segment table and the reset pattern.
package seq_disp_pkg;

    // Segment bit positions within the 8-bit segment drive.
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Active-high a..g patterns for hex digits 0..F, indexed by digit value.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71,  // F
        7'h79,  // E
        7'h5E,  // d
        7'h39,  // C
        7'h7C,  // b
        7'h77,  // A
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

    // Active-high pattern shown while in reset: digit 0, dp off.
    localparam logic [7:0] SEG_RESET_PATTERN = 8'h3F;

    // Apply the board's segment polarity to an active-high pattern.
    function automatic logic [7:0] seg_polarity(input logic [7:0] seg_ah,
                                                input bit         active_high);
        return active_high ? seg_ah : ~seg_ah;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to seven-segment (a..g) decoder, active-high.
module seg7_hex_decode
    import seq_disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Pure table lookup; polarity is applied by the caller.
    always_comb begin
        seg_o = HEX_SEG_TABLE[hex_i];
    end

endmodule

// File: rtl/seq_event_display.sv
// Counts rising edges of the upstream detect level, shows the count as a hex
// digit and stretches each event onto the decimal point for HOLD_CYCLES.
// A wrap of the 4-bit count sets a sticky overflow flag.
//
// Timing: an event seen before edge k is visible on count, ovf and seg right
// after edge k, because seg is registered from next-state values.
module seq_event_display
    import seq_disp_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES     = 8,
    parameter bit          SEG_ACTIVE_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       det,
    input  logic       clr,
    output logic [7:0] seg,
    output logic       ovf
);

    localparam int unsigned STRETCH_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(HOLD_CYCLES);

    logic                 det_q;
    logic [3:0]           count_q,   count_d;
    logic                 ovf_q,     ovf_d;
    logic [STRETCH_W-1:0] stretch_q, stretch_d;
    logic [7:0]           seg_q,     seg_d;
    logic                 event_w;
    logic [6:0]           digit_seg;

    // One event per det rising edge; det_q resets high so a level already
    // present at reset release is not counted.
    assign event_w = det & ~det_q;

    // Next-state for count, overflow and dp stretch; clear beats event.
    always_comb begin
        count_d   = count_q;
        ovf_d     = ovf_q;
        stretch_d = stretch_q;
        if (clr) begin
            count_d   = 4'd0;
            ovf_d     = 1'b0;
            stretch_d = '0;
        end else if (event_w) begin
            count_d   = count_q + 4'd1;
            ovf_d     = ovf_q | (count_q == 4'hF);
            stretch_d = STRETCH_LOAD;
        end else if (stretch_q != '0) begin
            stretch_d = stretch_q - STRETCH_W'(1);
        end
    end

    // Decode the next count so the display has no added latency.
    seg7_hex_decode u_decode (
        .hex_i (count_d),
        .seg_o (digit_seg)
    );

    // Assemble the next segment word: dp lit while the stretch is running.
    always_comb begin
        seg_d = {(stretch_d != '0), digit_seg};
    end

    // Edge-detect history; keeps tracking det during clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            det_q <= 1'b1;
        end else begin
            det_q <= det;
        end
    end

    // Count, overflow, stretch and registered segment drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= 4'd0;
            ovf_q     <= 1'b0;
            stretch_q <= '0;
            seg_q     <= seg_polarity(SEG_RESET_PATTERN, SEG_ACTIVE_HIGH);
        end else begin
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            stretch_q <= stretch_d;
            seg_q     <= seg_polarity(seg_d, SEG_ACTIVE_HIGH);
        end
    end

    assign seg = seg_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_seq_event_display.sv
// Bench for seq_event_display: two instances (both polarities) share the
// same stimulus and are compared every cycle against an event-history model.
module tb_seq_event_display;

  localparam int HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic       det;
  logic       clr;
  logic [7:0] seg_ah, seg_al;
  logic       ovf_ah, ovf_al;

  seq_event_display #(.HOLD_CYCLES(HOLD), .SEG_ACTIVE_HIGH(1'b1)) u_dut_ah (
    .clk   (clk),
    .rst_n (rst_n),
    .det   (det),
    .clr   (clr),
    .seg   (seg_ah),
    .ovf   (ovf_ah)
  );

  seq_event_display #(.HOLD_CYCLES(HOLD), .SEG_ACTIVE_HIGH(1'b0)) u_dut_al (
    .clk   (clk),
    .rst_n (rst_n),
    .det   (det),
    .clr   (clr),
    .seg   (seg_al),
    .ovf   (ovf_al)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [6:0] hex_tbl [16];

  // model: history of events since the last clear/reset
  int         cyc = 0;
  int         m_events = 0;
  int         m_last_evt = 0;
  bit         m_have_evt = 1'b0;
  bit         m_det_prev = 1'b1;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %02h expected %02h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] model_seg();
    bit dp;
    dp = m_have_evt && ((cyc - m_last_evt) < HOLD);
    return {dp, hex_tbl[m_events % 16]};
  endfunction

  // driver: apply one cycle of inputs, advance the model, check both DUTs
  task automatic step(input logic d, input logic c, input logic r);
    logic [7:0] e;
    det = d; clr = c; rst_n = r;
    @(posedge clk);
    cyc++;
    if (!r) begin
      m_events = 0; m_have_evt = 1'b0; m_det_prev = 1'b1;
    end else begin
      bit ev;
      ev = d && !m_det_prev;
      m_det_prev = d;
      if (c) begin
        m_events = 0; m_have_evt = 1'b0;
      end else if (ev) begin
        m_events++; m_last_evt = cyc; m_have_evt = 1'b1;
      end
    end
    e = model_seg();
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    check_val("seg_ah", seg_ah, e);
    check_val("seg_al", seg_al, ~e);
    check_val("ovf_ah", {7'd0, ovf_ah}, {7'd0, (m_events >= 16)});
    check_val("ovf_al", {7'd0, ovf_al}, {7'd0, (m_events >= 16)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    det = 1'b1; clr = 1'b0; rst_n = 1'b0;

    // reset with det held high through release: no count
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_val("reset_seg", seg_ah, 8'h3F);
    check_val("reset_seg_inv", seg_al, 8'hC0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    check_val("no_count_release", seg_ah, 8'h3F);

    // single one-cycle pulse
    idle(2);
    step(1'b1, 1'b0, 1'b1);
    check_val("single_dp", seg_ah, 8'h86);
    idle(HOLD);
    check_val("single_after", seg_ah, 8'h06);

    // held level counts once
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1);
    idle(2);
    check_val("held_once", seg_ah, 8'h5B);

    // wrap and clear
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
    end
    check_val("wrap_seg", seg_ah, 8'hBF);
    check_val("wrap_ovf", {7'd0, ovf_ah}, 8'd1);
    step(1'b0, 1'b1, 1'b1);
    check_val("clr_seg", seg_ah, 8'h3F);
    check_val("clr_ovf", {7'd0, ovf_ah}, 8'd0);

    // clr beats a coincident det rise; next rise counts
    step(1'b1, 1'b1, 1'b1);
    check_val("prio_seg", seg_ah, 8'h3F);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check_val("prio_next", seg_ah, 8'h86);

    // reload: second event 3 cycles after the first extends dp
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 1'b1);
    idle(HOLD - 1);
    check_val("reload_lit_inv", seg_al, ~8'hDB);
    idle(1);
    check_val("reload_off_inv", seg_al, ~8'h5B);

    // reset mid-stretch overrides an event
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check_val("rst_mid", seg_ah, 8'h3F);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      logic d, c, r;
      d = ($urandom_range(0, 3) == 0) ? ~det : det;
      c = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 199) != 0);
      step(d, c, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
